// File: rtl/light_package.sv
// Shared traffic-light types, sensor-lane FSM states and default conditioning timings.
package light_package;

  typedef enum logic [1:0] {red, yellow, green} colors;

  typedef enum logic [1:0] {IDLE, QUAL, PRESENT, HOLD} lane_state_t;

  localparam int DEFAULT_DEB_CYCLES   = 3;
  localparam int DEFAULT_HOLD_CYCLES  = 2;
  localparam int DEFAULT_STUCK_CYCLES = 64;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sensor_lane.sv
// One loop-detector lane: synchroniser, debounce/hold FSM, call latch.
// Optional stuck-detector counter when SENSOR_STUCK_DET_EN is defined.
module sensor_lane
  import light_package::*;
#(
  parameter int DEB_CYCLES   = DEFAULT_DEB_CYCLES,
  parameter int HOLD_CYCLES  = DEFAULT_HOLD_CYCLES
`ifdef SENSOR_STUCK_DET_EN
  ,
  parameter int STUCK_CYCLES = DEFAULT_STUCK_CYCLES
`endif
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  raw,
  input  colors light,
  output logic  sensor
`ifdef SENSOR_STUCK_DET_EN
  ,
  output logic  stuck_fault
`endif
);

  localparam int CNT_W = $clog2(max2(DEB_CYCLES, HOLD_CYCLES)) + 1;
  // The sample taken on the deciding edge counts too, so thresholds sit one below the parameter.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic sync1;
  logic s;
  logic call_latch;
  logic fault;
  logic force_idle;

  lane_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

`ifdef SENSOR_STUCK_DET_EN
  localparam int STK_W = $clog2(STUCK_CYCLES) + 1;
  localparam logic [STK_W-1:0] STUCK_LAST = STK_W'(STUCK_CYCLES - 1);
  localparam logic [STK_W-1:0] STUCK_MAX  = STK_W'(STUCK_CYCLES);

  logic [STK_W-1:0] stuck_cnt;

  assign force_idle = s && (stuck_cnt >= STUCK_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stuck_cnt <= '0;
      fault     <= 1'b0;
    end else begin
      fault <= force_idle;
      if (!s)
        stuck_cnt <= '0;
      else if (stuck_cnt < STUCK_MAX)
        stuck_cnt <= stuck_cnt + 1'b1;
    end
  end

  assign stuck_fault = fault;
`else
  assign force_idle = 1'b0;
  assign fault      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (s) begin
          if (DEB_CYCLES <= 1) begin
            state_next = PRESENT;
            cnt_next   = '0;
          end else begin
            state_next = QUAL;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      QUAL: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt >= DEB_LAST) begin
          state_next = PRESENT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PRESENT: begin
        if (!s) begin
          state_next = HOLD;
          cnt_next   = CNT_W'(1);
        end
      end
      HOLD: begin
        if (s) begin
          state_next = PRESENT;
          cnt_next   = '0;
        end else if (cnt >= HOLD_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (force_idle) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  // A green light serves the call, so clearing takes priority over setting.
  always_ff @(posedge clk) begin
    if (!reset_n)
      call_latch <= 1'b0;
    else if (light == green || force_idle)
      call_latch <= 1'b0;
    else if (state == PRESENT && light == red)
      call_latch <= 1'b1;
  end

  always_comb begin
    sensor = !fault && ((state == PRESENT) || (state == HOLD) || call_latch);
  end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the three raw loop detectors into controller sensor requests.
// SENSOR_STUCK_DET_EN adds per-lane stuck-detector faults on stuck_fault {ns, ew_left, ew_str}.
module traffic_sensor_conditioner
  import light_package::*;
#(
  parameter int DEB_CYCLES   = DEFAULT_DEB_CYCLES,
  parameter int HOLD_CYCLES  = DEFAULT_HOLD_CYCLES
`ifdef SENSOR_STUCK_DET_EN
  ,
  parameter int STUCK_CYCLES = DEFAULT_STUCK_CYCLES
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       raw_ew_str,
  input  logic       raw_ew_left,
  input  logic       raw_ns,
  input  colors      ew_str_light,
  input  colors      ew_left_light,
  input  colors      ns_light,
  output logic       ew_str_sensor,
  output logic       ew_left_sensor,
  output logic       ns_sensor
`ifdef SENSOR_STUCK_DET_EN
  ,
  output logic [2:0] stuck_fault
`endif
);

`ifdef SENSOR_STUCK_DET_EN
  sensor_lane #(.DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_ew_str (
    .clk(clk), .reset_n(reset_n), .raw(raw_ew_str), .light(ew_str_light),
    .sensor(ew_str_sensor), .stuck_fault(stuck_fault[0])
  );
  sensor_lane #(.DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_ew_left (
    .clk(clk), .reset_n(reset_n), .raw(raw_ew_left), .light(ew_left_light),
    .sensor(ew_left_sensor), .stuck_fault(stuck_fault[1])
  );
  sensor_lane #(.DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)) u_ns (
    .clk(clk), .reset_n(reset_n), .raw(raw_ns), .light(ns_light),
    .sensor(ns_sensor), .stuck_fault(stuck_fault[2])
  );
`else
  sensor_lane #(.DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES)) u_ew_str (
    .clk(clk), .reset_n(reset_n), .raw(raw_ew_str), .light(ew_str_light),
    .sensor(ew_str_sensor)
  );
  sensor_lane #(.DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES)) u_ew_left (
    .clk(clk), .reset_n(reset_n), .raw(raw_ew_left), .light(ew_left_light),
    .sensor(ew_left_sensor)
  );
  sensor_lane #(.DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES)) u_ns (
    .clk(clk), .reset_n(reset_n), .raw(raw_ns), .light(ns_light),
    .sensor(ns_sensor)
  );
`endif

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Self-checking bench: reset/glitch vector table, directed multi-cycle sequences,
// then randomized traffic against a behavioural run-length model of each lane.
module tb_traffic_sensor_conditioner;
  import light_package::*;

  localparam int DEB   = 3;
  localparam int HOLD  = 2;
  localparam int STUCK = 64;
  localparam int NUM_RANDOM = 3000;

  logic  clk = 1'b0;
  logic  reset_n;
  logic  raw_ew_str, raw_ew_left, raw_ns;
  colors ew_str_light, ew_left_light, ns_light;
  logic  ew_str_sensor, ew_left_sensor, ns_sensor;
`ifdef SENSOR_STUCK_DET_EN
  logic [2:0] stuck_fault;
`endif

  int checks = 0;
  int errors = 0;

  // Model state per lane: synchroniser stages, run lengths and request flags.
  logic q1 [3];
  logic q2 [3];
  int   hi_run [3];
  int   lo_run [3];
  logic m_active [3];
  logic m_present [3];
  logic m_latch [3];
  logic m_fault [3];

  typedef struct {
    logic       rn;
    logic [2:0] raw;
    colors      ls;
    colors      ll;
    colors      ln;
    logic [2:0] exp;
  } vec_t;

  vec_t tbl [18];

  traffic_sensor_conditioner dut (
    .clk(clk),
    .reset_n(reset_n),
    .raw_ew_str(raw_ew_str),
    .raw_ew_left(raw_ew_left),
    .raw_ns(raw_ns),
    .ew_str_light(ew_str_light),
    .ew_left_light(ew_left_light),
    .ns_light(ns_light),
    .ew_str_sensor(ew_str_sensor),
    .ew_left_sensor(ew_left_sensor),
    .ns_sensor(ns_sensor)
`ifdef SENSOR_STUCK_DET_EN
    ,
    .stuck_fault(stuck_fault)
`endif
  );

  always #5 clk = ~clk;

  task automatic stepModel(input logic rn, input logic [2:0] raw, input colors ls, input colors ll, input colors ln);
    colors lt [3];
    logic  s;
    lt[0] = ls; lt[1] = ll; lt[2] = ln;
    for (int i = 0; i < 3; i++) begin
      if (!rn) begin
        q1[i] = 0; q2[i] = 0; hi_run[i] = 0; lo_run[i] = 0;
        m_active[i] = 0; m_present[i] = 0; m_latch[i] = 0; m_fault[i] = 0;
      end else begin
        s = q2[i];
        q2[i] = q1[i];
        q1[i] = raw[i];
        if (lt[i] == green) m_latch[i] = 0;
        else if (lt[i] == red && m_present[i]) m_latch[i] = 1;
        if (s) begin
          if (hi_run[i] <= STUCK) hi_run[i]++;
          lo_run[i] = 0;
        end else begin
          hi_run[i] = 0;
          if (lo_run[i] < 1000) lo_run[i]++;
        end
        if (m_active[i]) begin
          if (s) m_present[i] = 1;
          else begin
            m_present[i] = 0;
            if (lo_run[i] >= HOLD) m_active[i] = 0;
          end
        end else if (s && hi_run[i] >= DEB) begin
          m_active[i] = 1;
          m_present[i] = 1;
        end
`ifdef SENSOR_STUCK_DET_EN
        m_fault[i] = s && (hi_run[i] >= STUCK);
        if (m_fault[i]) begin
          m_active[i] = 0; m_present[i] = 0; m_latch[i] = 0;
        end
`endif
      end
    end
  endtask

  function automatic logic [2:0] modelSensors();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (m_active[i] | m_latch[i]) & ~m_fault[i];
    return r;
  endfunction

  task automatic applyStimulus(input logic rn, input logic [2:0] raw, input colors ls, input colors ll, input colors ln);
    @(negedge clk);
    reset_n       = rn;
    raw_ew_str    = raw[0];
    raw_ew_left   = raw[1];
    raw_ns        = raw[2];
    ew_str_light  = ls;
    ew_left_light = ll;
    ns_light      = ln;
    @(posedge clk);
    #1;
    stepModel(rn, raw, ls, ll, ln);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic idleGap();
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 3'b000, green, green, green);
  endtask

  task automatic holdExtension();
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(1'b1, {1'b0, (e <= 6), 1'b0}, red, green, red);
      checkOutput($sformatf("hold_ext e%0d", e), {2'b00, ew_left_sensor}, {2'b00, (e >= 5 && e <= 9)});
    end
  endtask

  task automatic latchedCall();
    colors l;
    for (int e = 1; e <= 37; e++) begin
      l = (e <= 30) ? red : (e <= 35) ? yellow : green;
      applyStimulus(1'b1, {2'b00, (e <= 5)}, l, green, green);
      checkOutput($sformatf("latched_call e%0d", e), {2'b00, ew_str_sensor}, {2'b00, (e >= 5 && e <= 35)});
    end
  endtask

  task automatic setClearRace();
    for (int e = 1; e <= 14; e++) begin
      applyStimulus(1'b1, {(e <= 8), 2'b00}, green, green, (e <= 5) ? red : green);
      checkOutput($sformatf("set_clear e%0d", e), {2'b00, ns_sensor}, {2'b00, (e >= 5 && e <= 11)});
    end
  endtask

`ifdef SENSOR_STUCK_DET_EN
  task automatic stuckDetector();
    for (int e = 1; e <= 106; e++) begin
      applyStimulus(1'b1, {(e <= 100), 2'b00}, green, green, red);
      checkOutput($sformatf("stuck_fault e%0d", e), {2'b00, stuck_fault[2]}, {2'b00, (e >= 66 && e <= 102)});
      checkOutput($sformatf("stuck_sensor e%0d", e), {2'b00, ns_sensor}, {2'b00, (e >= 5 && e <= 65)});
    end
  endtask
`endif

  initial begin
    logic [2:0] rraw;
    colors      rl [3];
    logic       rn;

    reset_n = 1'b0;
    raw_ew_str = 1'b1; raw_ew_left = 1'b1; raw_ns = 1'b1;
    ew_str_light = green; ew_left_light = green; ns_light = green;
    for (int i = 0; i < 3; i++) begin
      q1[i] = 0; q2[i] = 0; hi_run[i] = 0; lo_run[i] = 0;
      m_active[i] = 0; m_present[i] = 0; m_latch[i] = 0; m_fault[i] = 0;
    end

    tbl[0]  = '{1'b0, 3'b111, green, green, green, 3'b000};
    tbl[1]  = '{1'b0, 3'b111, green, green, green, 3'b000};
    tbl[2]  = '{1'b1, 3'b111, green, green, green, 3'b000};
    tbl[3]  = '{1'b1, 3'b111, green, green, green, 3'b000};
    tbl[4]  = '{1'b1, 3'b111, green, green, green, 3'b000};
    tbl[5]  = '{1'b1, 3'b111, green, green, green, 3'b000};
    tbl[6]  = '{1'b1, 3'b111, green, green, green, 3'b111};
    tbl[7]  = '{1'b1, 3'b000, green, green, green, 3'b111};
    tbl[8]  = '{1'b1, 3'b000, green, green, green, 3'b111};
    tbl[9]  = '{1'b1, 3'b000, green, green, green, 3'b111};
    tbl[10] = '{1'b1, 3'b000, green, green, green, 3'b000};
    tbl[11] = '{1'b1, 3'b100, green, green, red,   3'b000};
    tbl[12] = '{1'b1, 3'b100, green, green, red,   3'b000};
    for (int i = 13; i < 18; i++) tbl[i] = '{1'b1, 3'b000, green, green, red, 3'b000};

    $display("[TB] reset and glitch vector table");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].rn, tbl[i].raw, tbl[i].ls, tbl[i].ll, tbl[i].ln);
      checkOutput($sformatf("table[%0d]", i), {ns_sensor, ew_left_sensor, ew_str_sensor}, tbl[i].exp);
`ifdef SENSOR_STUCK_DET_EN
      checkOutput($sformatf("table_fault[%0d]", i), stuck_fault, 3'b000);
`endif
    end

    $display("[TB] directed sequences");
    idleGap();
    holdExtension();
    idleGap();
    latchedCall();
    idleGap();
    setClearRace();
    idleGap();
`ifdef SENSOR_STUCK_DET_EN
    stuckDetector();
    idleGap();
`endif

    $display("[TB] randomized traffic against reference model");
    rraw = 3'b000;
    rl[0] = red; rl[1] = red; rl[2] = red;
    for (int n = 0; n < NUM_RANDOM; n++) begin
      rn = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 5) == 0) rraw[i] = ~rraw[i];
        if ($urandom_range(0, 9) == 0) rl[i] = colors'($urandom_range(0, 2));
      end
      applyStimulus(rn, rraw, rl[0], rl[1], rl[2]);
      checkOutput($sformatf("random[%0d]", n), {ns_sensor, ew_left_sensor, ew_str_sensor}, modelSensors());
`ifdef SENSOR_STUCK_DET_EN
      checkOutput($sformatf("random_fault[%0d]", n), stuck_fault, {m_fault[2], m_fault[1], m_fault[0]});
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
